// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-addressable data memory with self-clearing init and optional misalign trap
// Optional feature: define DATA_MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module data_mem #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemSize,
    input  logic        ExtSign,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        FaultValid,
    output logic [31:0] FaultAddr,
    input  logic        FaultClr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {INIT, READY} state_t;

    state_t          state;
    logic [AW-1:0]   init_idx;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            size_ok;
    logic            blocked;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    assign word_idx = Addr[AW+1:2];
    assign size_ok  = (MemSize != 2'b11);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((MemSize == 2'b01) && Addr[0]) ||
                        ((MemSize == 2'b10) && (Addr[1:0] != 2'b00));
    assign lane    = Addr[1:0];
    assign blocked = misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            FaultValid <= 1'b0;
            FaultAddr  <= '0;
        end else if (FaultClr) begin
            FaultValid <= 1'b0;
            FaultAddr  <= '0;
        end else if (state == READY && (MemRead || MemWrite) && misaligned && !FaultValid) begin
            FaultValid <= 1'b1;
            FaultAddr  <= Addr;
        end
    end
`else
    logic unused_in;
    assign unused_in  = ^{FaultClr, Addr[31:AW+2]};
    assign blocked    = 1'b0;
    assign FaultValid = 1'b0;
    assign FaultAddr  = '0;

    // Misaligned halves/words silently snap down to their natural boundary.
    always_comb begin
        lane = Addr[1:0];
        if (MemSize == 2'b01)
            lane[0] = 1'b0;
        else if (MemSize == 2'b10)
            lane = 2'b00;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
            Ready    <= 1'b0;
        end else if (state == INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == AW'(DEPTH_WORDS - 1)) begin
                state <= READY;
                Ready <= 1'b1;
            end
        end
    end

    // Single write port shared between the init sweep and stores.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_be   = 4'b0000;
        wr_data = '0;
        if (state == INIT) begin
            wr_en  = 1'b1;
            wr_idx = init_idx;
            wr_be  = 4'b1111;
        end else if (MemWrite && size_ok && !blocked) begin
            wr_en = 1'b1;
            case (MemSize)
                2'b00: begin
                    wr_be   = 4'b0001 << lane;
                    wr_data = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{WriteData[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = WriteData;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ReadData = '0;
        if (state == READY && MemRead && size_ok && !blocked) begin
            case (MemSize)
                2'b00:   ReadData = {{24{ExtSign & rd_byte[7]}}, rd_byte};
                2'b01:   ReadData = {{16{ExtSign & rd_half[15]}}, rd_half};
                default: ReadData = rd_word;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem against a byte-array reference model
module tb_data_mem;
    localparam int DEPTH  = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        ext_sign = 1'b0;
    logic [31:0] read_data;
    logic        ready;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic        fault_clr = 1'b0;

    always #5 clk = ~clk;

    data_mem #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .Addr(addr), .WriteData(wdata),
        .MemWrite(mem_write), .MemRead(mem_read), .MemSize(mem_size),
        .ExtSign(ext_sign), .ReadData(read_data), .Ready(ready),
        .FaultValid(fault_valid), .FaultAddr(fault_addr), .FaultClr(fault_clr)
    );

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        exp_fv = 1'b0;
    logic [31:0] exp_fa = '0;
    bit          run_chk = 1'b0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic int base_of(input logic [31:0] a, input logic [1:0] s);
        int b;
        b = int'(a % NBYTES);
        if (s == 2'd1) b = b - (b % 2);
        if (s == 2'd2) b = b - (b % 4);
        return b;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic e);
        int b;
        logic [15:0] h;
        if (s == 2'd3) return 32'h0;
        if (TRAP && misal(a, s)) return 32'h0;
        b = base_of(a, s);
        case (s)
            2'd0:    return (e && ref_mem[b][7]) ? {24'hFFFFFF, ref_mem[b]} : {24'h0, ref_mem[b]};
            2'd1: begin
                h = {ref_mem[b+1], ref_mem[b]};
                return (e && h[15]) ? {16'hFFFF, h} : {16'h0, h};
            end
            default: return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int b;
        int n;
        if (s == 2'd3) return;
        if (TRAP && misal(a, s)) return;
        b = base_of(a, s);
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[b+i] = d[8*i +: 8];
    endtask

    task automatic clear_model();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        exp_fv = 1'b0;
        exp_fa = '0;
    endtask

    // One READY-phase access, entered and left at posedge+1.
    task automatic op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input bit e, input bit clr, input string nm);
        logic        nfv;
        logic [31:0] nfa;
        addr = a; wdata = d; mem_write = we; mem_read = re;
        mem_size = s; ext_sign = e; fault_clr = clr;
        if (re) begin
            exp_q.push_back(model_load(a, s, e));
            name_q.push_back(nm);
        end
        nfv = exp_fv;
        nfa = exp_fa;
        if (TRAP) begin
            if (clr) begin
                nfv = 1'b0;
                nfa = '0;
            end else if ((we || re) && misal(a, s) && !exp_fv) begin
                nfv = 1'b1;
                nfa = a;
            end
        end
        @(posedge clk);
        #1;
        exp_fv = nfv;
        exp_fa = nfa;
        if (we) model_store(a, d, s);
        mem_write = 1'b0; mem_read = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
            mem_write = 1'b0;
            mem_read = 1'b0;
        end
        check32(nm, cnt, 256);
    endtask

    always @(negedge clk) begin
        if (mem_read) begin
            if (exp_q.size() == 0) begin
                check32("unexpected_read", 32'h1, 32'h0);
            end else begin
                check32(name_q.pop_front(), read_data, exp_q.pop_front());
            end
        end else if (run_chk) begin
            check32("idle_read_zero", read_data, 32'h0);
        end
        if (run_chk) begin
            check32("ready_high", {31'h0, ready}, 32'h1);
            check32("fault_valid", {31'h0, fault_valid}, {31'h0, exp_fv});
            check32("fault_addr", fault_addr, exp_fa);
        end
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check32("rst_ready", {31'h0, ready}, 32'h0);
        check32("rst_fault_valid", {31'h0, fault_valid}, 32'h0);
        check32("rst_fault_addr", fault_addr, 32'h0);

        // Store + read in the first INIT cycle: write ignored, read returns 0.
        rst = 1'b0;
        addr = 32'h10; wdata = 32'hDEADBEEF; mem_size = 2'd2; mem_write = 1'b1; mem_read = 1'b1;
        exp_q.push_back(32'h0);
        name_q.push_back("init_read_zero");
        wait_ready("init_len");

        run_chk = 1'b1;
        op(0, 1, 32'h40, 0, 2'd2, 0, 0, "cleared_word");
        op(0, 1, 32'h10, 0, 2'd2, 0, 0, "init_store_dropped");

        op(1, 0, 32'h10, 32'h80FF7F01, 2'd2, 0, 0, "");
        op(0, 1, 32'h11, 0, 2'd0, 0, 0, "lb_zext_0x11");
        op(0, 1, 32'h12, 0, 2'd0, 1, 0, "lb_sext_0x12");
        op(0, 1, 32'h12, 0, 2'd1, 1, 0, "lh_sext_0x12");
        op(0, 1, 32'h12, 0, 2'd2, 1, 0, "lw_ext_ignored");

        op(1, 0, 32'h20, 32'h11223344, 2'd2, 0, 0, "");
        op(1, 0, 32'h23, 32'h000000AB, 2'd0, 0, 0, "");
        op(0, 1, 32'h20, 0, 2'd2, 0, 0, "byte_merge");

        op(1, 0, 32'h04, 32'hCAFEF00D, 2'd2, 0, 0, "");
        op(0, 1, 32'h06, 0, 2'd2, 0, 0, "misaligned_word_load");
        op(1, 0, 32'h06, 32'h12345678, 2'd2, 0, 0, "");
        op(0, 1, 32'h04, 0, 2'd2, 0, 0, "after_misaligned_store");
        op(1, 1, 32'h09, 32'h0000BEEF, 2'd1, 0, 0, "second_fault_rw");
        op(0, 0, 32'h0, 0, 2'd0, 0, 1, "");
        op(1, 1, 32'h30, 32'h55667788, 2'd3, 0, 0, "reserved_size");
        op(0, 1, 32'h30, 0, 2'd2, 0, 0, "reserved_no_write");
        op(1, 1, 32'h50, 32'hA5A5A5A5, 2'd2, 0, 0, "read_during_write");
        op(0, 1, 32'h50, 0, 2'd2, 0, 0, "write_committed");

        op(1, 0, 32'h3FC, 32'h89ABCDEF, 2'd2, 0, 0, "");
        op(0, 1, 32'h7FC, 0, 2'd2, 0, 0, "wrap_top_word");
        op(1, 0, 32'hFFFF_F401, 32'h00000077, 2'd0, 0, 0, "");
        op(0, 1, 32'h1, 0, 2'd0, 0, 0, "wrap_byte_low");

        for (int i = 0; i < 400; i++) begin
            ra = $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) ra = ra | ($urandom() & 32'hFFFF_FC00);
            rs = 2'($urandom_range(0, 3));
            op(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra, $urandom(), rs,
               bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), "rand_load");
        end

        // Reset mid-READY, then again 100 cycles into INIT with a store in flight.
        run_chk = 1'b0;
        rst = 1'b1;
        addr = 32'h30; wdata = 32'hFFFFFFFF; mem_size = 2'd2; mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        clear_model();
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        addr = 32'h30; mem_write = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check32("mid_init_ready_low", {31'h0, ready}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        rst = 1'b0;
        wait_ready("reinit_len");

        run_chk = 1'b1;
        op(0, 1, 32'h30, 0, 2'd2, 0, 0, "init_store_not_kept");
        op(0, 1, 32'h10, 0, 2'd2, 0, 0, "reinit_cleared");
        op(0, 0, 32'h0, 0, 2'd0, 0, 0, "");
        run_chk = 1'b0;
        check32("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL expose parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words stored; it is a power of two, minimum 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port Addr, input, 32 bits: byte address, the ALU result.
REQ-005 SHALL have port WriteData, input, 32 bits: store data, the rs2 value.
REQ-006 SHALL have port MemWrite, input, 1 bit: store request for the current cycle.
REQ-007 SHALL have port MemRead, input, 1 bit: load request for the current cycle.
REQ-008 SHALL have port MemSize, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port ExtSign, input, 1 bit: 1 sign-extends load data, 0 zero-extends it.
REQ-010 SHALL have port ReadData, output, 32 bits: extended load result, combinational.
REQ-011 SHALL have port Ready, output, 1 bit: memory initialised and accepting accesses.
REQ-012 SHALL have port FaultValid, output, 1 bit: sticky misaligned-access flag.
REQ-013 SHALL have port FaultAddr, output, 32 bits: Addr of the first faulting access.
REQ-014 SHALL have port FaultClr, input, 1 bit: clears FaultValid and FaultAddr.

Function
REQ-015 SHALL implement a two-state FSM: INIT and READY.
REQ-016 In INIT, SHALL zero one word per cycle at the init index, counting 0 to DEPTH_WORDS-1, then enter READY; INIT lasts exactly DEPTH_WORDS cycles.
REQ-017 Ready SHALL be 0 in INIT and 1 in READY.
REQ-018 In INIT, SHALL ignore MemWrite and drive ReadData to 0.
REQ-019 SHALL form the word index from Addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so the address space wraps.
REQ-020 A store (MemWrite=1 in READY) SHALL update memory at the clock edge:
- byte: WriteData[7:0] goes to lane Addr[1:0].
- half: WriteData[15:0] goes to lanes {Addr[1],0} and {Addr[1],1}.
- word: all four lanes are written.
- all other lanes are unchanged.
REQ-021 MemSize=11 SHALL perform no write and drive ReadData to 0.
REQ-022 Load (MemRead=1 in READY) SHALL be zero-latency:
- ReadData is the selected byte or half (lane per REQ-020), or the full word.
- the result is extended per ExtSign; ExtSign is ignored for word loads.
REQ-023 With MemRead=0, ReadData SHALL be 0.
REQ-024 With MemRead=1 and MemWrite=1 in the same cycle, ReadData SHALL return the pre-write contents, and the write commits at the edge.
REQ-025 A misaligned access SHALL be a half access with Addr[0]=1, or a word access with Addr[1:0]!=00; its handling is governed by REQ-030 and REQ-031.
REQ-026 FaultClr SHALL take priority over a simultaneous new fault: the registers clear, and that fault is not captured.

Reset
REQ-027 On rst=1 at a clock edge, SHALL:
- enter INIT;
- set the init index to 0;
- set Ready=0, FaultValid=0 and FaultAddr=0.
REQ-028 Reset asserted mid-INIT or mid-READY SHALL restart the clear from index 0; any store in the same cycle is dropped.
REQ-029 Outputs SHALL hold their reset values while rst=1.

Configuration
REQ-030 With macro DATA_MEM_MISALIGN_TRAP_EN defined, a misaligned access in READY SHALL:
- suppress the write;
- drive ReadData to 0;
- if FaultValid=0, set FaultValid=1 and capture Addr into FaultAddr;
- if FaultValid=1, leave FaultAddr holding the first fault.
REQ-031 Without DATA_MEM_MISALIGN_TRAP_EN, SHALL:
- force the low address bits to alignment (Addr[0] for half accesses, Addr[1:0] for word accesses) and perform the access;
- tie FaultValid and FaultAddr to 0;
- ignore FaultClr.

Verification
REQ-032 Deassert rst, DEPTH_WORDS=256 -> Ready rises after exactly 256 cycles; a read of any word returns 0x00000000.
REQ-033 Store word 0x80FF7F01 to 0x10; then load byte 0x11 with ExtSign=0, byte 0x12 with ExtSign=1, and half 0x12 with ExtSign=1 -> 0x0000007F, 0xFFFFFFFF, 0xFFFF80FF.
REQ-034 Store byte 0xAB to 0x23 over word 0x11223344 -> word reads 0xAB223344.
REQ-035 With the macro defined: store word to 0x06 -> memory unchanged, FaultValid=1, FaultAddr=0x00000006; a second fault at 0x09 leaves FaultAddr unchanged; FaultClr -> both clear.
REQ-036 Without the macro: load word from 0x06 -> returns the word at 0x04, FaultValid stays 0.
REQ-037 Assert rst at INIT cycle 100 -> Ready rises 256 cycles after rst deasserts; a store issued during INIT is not retained.
